regex_cpu_windowed: RTL

REGEX_CPU_WINDOWED -- requirements
Module: regex_cpu_windowed

---
 rtl/regex_cpu_windowed_pkg.sv | 29 ++
 rtl/regex_cpu_windowed_decoder.sv | 88 ++++++++
 rtl/regex_cpu_windowed.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/regex_cpu_windowed_pkg.sv
// Shared instruction definitions for the windowed regex CPU: opcode encoding,
// instruction field widths and the controller state encoding.
package regex_cpu_windowed_pkg;

  localparam int OPCODE_WIDTH = 3;
  // Data field width for the default 16-bit instruction word.
  localparam int INSTRUCTION_DATA_WIDTH = 16 - OPCODE_WIDTH;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ACCEPT                = 3'd0,
    OP_SPLIT                 = 3'd1,
    OP_MATCH                 = 3'd2,
    OP_JMP                   = 3'd3,
    OP_END_WITHOUT_ACCEPTING = 3'd4,
    OP_MATCH_ANY             = 3'd5,
    OP_ACCEPT_PARTIAL        = 3'd6,
    OP_NOT_MATCH             = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_OUT_A,
    S_OUT_B
  } state_e;

endpackage

// File: rtl/regex_cpu_windowed_decoder.sv
// Combinational instruction decoder: given the fetched instruction, the
// thread's pc/window slot and the character window, produce the successor
// thread(s) and the accept decision.
module regex_cpu_decoder
  import regex_cpu_windowed_pkg::*;
#(
  parameter int PC_WIDTH        = 8,
  parameter int CHARACTER_WIDTH = 8,
  parameter int MEMORY_WIDTH    = 16,
  parameter int CC_ID_BITS      = 2
) (
  input  logic [MEMORY_WIDTH-1:0]                   instruction,
  input  logic [PC_WIDTH-1:0]                       pc,
  input  logic [CC_ID_BITS-1:0]                     cc_id,
  input  logic [CHARACTER_WIDTH*(2**CC_ID_BITS)-1:0] current_characters,
  output logic                                      emit,
  output logic                                      is_split,
  output logic                                      accept,
  output logic [PC_WIDTH-1:0]                       a_pc,
  output logic [CC_ID_BITS-1:0]                     a_cc,
  output logic [PC_WIDTH-1:0]                       b_pc,
  output logic [CC_ID_BITS-1:0]                     b_cc
);

  localparam int DATA_WIDTH = MEMORY_WIDTH - OPCODE_WIDTH;

  opcode_e                    op;
  logic [DATA_WIDTH-1:0]      data;
  logic [CHARACTER_WIDTH-1:0] c;
  logic [CHARACTER_WIDTH-1:0] literal;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic [PC_WIDTH-1:0]        target;
  logic [CC_ID_BITS-1:0]      nxt;
  logic                       unused_data;

  assign op      = opcode_e'(instruction[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign data    = instruction[DATA_WIDTH-1:0];
  assign c       = current_characters[cc_id*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign literal = data[CHARACTER_WIDTH-1:0];
  // Both increments wrap naturally at their register width.
  assign pc_inc  = pc + 1'b1;
  assign nxt     = cc_id + 1'b1;
  // Data bits above the pc field are deliberately ignored for jump targets.
  assign target  = data[PC_WIDTH-1:0];
  assign unused_data = ^data;

  // Decode the opcode into successor threads and the accept decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    emit     = 1'b0;
    is_split = 1'b0;
    accept   = 1'b0;
    a_pc     = pc_inc;
    a_cc     = cc_id;
    b_pc     = target;
    b_cc     = cc_id;
    case (op)
      OP_JMP: begin
        emit = 1'b1;
        a_pc = target;
      end
      OP_SPLIT: begin
        emit     = 1'b1;
        is_split = 1'b1;
      end
      OP_MATCH: begin
        if (c == literal) begin
          emit = 1'b1;
          a_cc = nxt;
        end
      end
      OP_NOT_MATCH: begin
        if (c != literal) begin
          emit = 1'b1;
          a_cc = nxt;
        end
      end
      OP_MATCH_ANY: begin
        emit = 1'b1;
        a_cc = nxt;
      end
      OP_ACCEPT:         accept = (c == '0);
      OP_ACCEPT_PARTIAL: accept = 1'b1;
      default:           ;
    endcase
  end

endmodule

// File: rtl/regex_cpu_windowed.sv
// Windowed regex CPU: runs one thread at a time through fetch, load, execute
// and up to two output handshakes, driving a single-port instruction memory.
module regex_cpu_windowed
  import regex_cpu_windowed_pkg::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int CC_ID_BITS        = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [CHARACTER_WIDTH*(2**CC_ID_BITS)-1:0] current_characters,
  input  logic                                      input_pc_valid,
  input  logic [PC_WIDTH-1:0]                       input_pc,
  input  logic [CC_ID_BITS-1:0]                     input_cc_id,
  output logic                                      input_pc_ready,
  output logic                                      memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]              memory_addr,
  input  logic                                      memory_ready,
  input  logic [MEMORY_WIDTH-1:0]                   memory_data,
  output logic                                      output_pc_valid,
  output logic [PC_WIDTH-1:0]                       output_pc,
  output logic [CC_ID_BITS-1:0]                     output_cc_id,
  input  logic                                      output_pc_ready,
  output logic                                      accepts
);

  state_e                    state;
  state_e                    state_next;

  logic [PC_WIDTH-1:0]       pc_q;
  logic [CC_ID_BITS-1:0]     cc_q;
  logic [MEMORY_WIDTH-1:0]   instr_q;
  logic [PC_WIDTH-1:0]       out_pc_q;
  logic [CC_ID_BITS-1:0]     out_cc_q;
  logic [PC_WIDTH-1:0]       b_pc_q;
  logic [CC_ID_BITS-1:0]     b_cc_q;
  logic                      split_q;
  logic                      accepts_q;

  logic                      dec_emit;
  logic                      dec_is_split;
  logic                      dec_accept;
  logic [PC_WIDTH-1:0]       dec_a_pc;
  logic [CC_ID_BITS-1:0]     dec_a_cc;
  logic [PC_WIDTH-1:0]       dec_b_pc;
  logic [CC_ID_BITS-1:0]     dec_b_cc;

  regex_cpu_decoder #(
    .PC_WIDTH        (PC_WIDTH),
    .CHARACTER_WIDTH (CHARACTER_WIDTH),
    .MEMORY_WIDTH    (MEMORY_WIDTH),
    .CC_ID_BITS      (CC_ID_BITS)
  ) u_decoder (
    .instruction        (instr_q),
    .pc                 (pc_q),
    .cc_id              (cc_q),
    .current_characters (current_characters),
    .emit               (dec_emit),
    .is_split           (dec_is_split),
    .accept             (dec_accept),
    .a_pc               (dec_a_pc),
    .a_cc               (dec_a_cc),
    .b_pc               (dec_b_pc),
    .b_cc               (dec_b_cc)
  );

  // State register; reset returns to IDLE from any state, aborting a fetch or output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (input_pc_valid) state_next = S_FETCH;
      S_FETCH: if (memory_ready)   state_next = S_LOAD;
      S_LOAD:  state_next = S_EXEC;
      S_EXEC:  state_next = dec_emit ? S_OUT_A : S_IDLE;
      S_OUT_A: if (output_pc_ready) state_next = split_q ? S_OUT_B : S_IDLE;
      S_OUT_B: if (output_pc_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode; all handshake outputs are held low while reset is asserted.
  always_comb begin
    input_pc_ready  = !rst && (state == S_IDLE);
    memory_valid    = !rst && (state == S_FETCH);
    output_pc_valid = !rst && ((state == S_OUT_A) || (state == S_OUT_B));
  end

  assign memory_addr  = MEMORY_ADDR_WIDTH'(pc_q);
  assign output_pc    = out_pc_q;
  assign output_cc_id = out_cc_q;
  assign accepts      = accepts_q && !rst;

  // Thread, instruction and result registers, loaded according to the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      cc_q      <= '0;
      instr_q   <= '0;
      out_pc_q  <= '0;
      out_cc_q  <= '0;
      b_pc_q    <= '0;
      b_cc_q    <= '0;
      split_q   <= 1'b0;
      accepts_q <= 1'b0;
    end else begin
      // accepts is a single-cycle pulse following the executing cycle.
      accepts_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (input_pc_valid) begin
            pc_q <= input_pc;
            cc_q <= input_cc_id;
          end
        end
        // Instruction is only captured here, so data arriving after an aborted fetch is dropped.
        S_LOAD: instr_q <= memory_data;
        S_EXEC: begin
          out_pc_q  <= dec_a_pc;
          out_cc_q  <= dec_a_cc;
          b_pc_q    <= dec_b_pc;
          b_cc_q    <= dec_b_cc;
          split_q   <= dec_is_split;
          accepts_q <= dec_accept;
        end
        S_OUT_A: begin
          if (output_pc_ready && split_q) begin
            out_pc_q <= b_pc_q;
            out_cc_q <= b_cc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
